// File: rtl/spinn_aer_out_if_pkg.sv
// Shared SpiNNaker-link packet layout used by the AER bridge interfaces.
// Holds the header/key field positions and the multicast type code.
package spinn_aer_out_if_pkg;

    localparam int SPINN_PKT_BITS = 72;
    localparam int HDR_BITS       = 8;
    localparam int HDR_TYPE_MSB   = 7;
    localparam int HDR_TYPE_LSB   = 6;
    localparam int KEY_LSB        = 8;
    localparam int KEY_BITS       = 32;

    localparam logic [1:0] PKT_TYPE_MC = 2'b00;

    typedef logic [KEY_BITS-1:0] key_t;

    function automatic logic is_multicast(input logic [1:0] pkt_type);
        return (pkt_type == PKT_TYPE_MC);
    endfunction

endpackage

// File: rtl/spinn_aer_out_if_aer_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset and a selectable
// preset value, shared by the inbound and outbound AER interfaces.
module aer_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of an input from outside the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spinn_aer_out_if.sv
// SpiNNaker -> AER outbound bridge: filters multicast packets, drives a 4-phase
// active-low req/ack AER bus, and falls back to dumping when the receiver stalls.
module spinn_aer_out_if
    import spinn_aer_out_if_pkg::*;
#(
    parameter int   PKT_BITS    = SPINN_PKT_BITS,
    parameter int   AER_BITS    = 16,
    parameter key_t KEY_MASK    = 32'hFFFF_0000,
    parameter key_t KEY_MATCH   = 32'h0000_0000,
    parameter int   ACK_TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    output logic                dump_mode,
    output logic                drop_pulse,
    input  logic [PKT_BITS-1:0] opkt_data,
    input  logic                opkt_vld,
    output logic                opkt_rdy,
    output logic [AER_BITS-1:0] aer_data,
    output logic                aer_req_n,
    input  logic                aer_ack_n
);

    localparam int TMR_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE_ST  = 3'd0,
        SETUP_ST = 3'd1,
        REQ_ST   = 3'd2,
        REL_ST   = 3'd3,
        DUMP_ST  = 3'd4
    } state_e;

    state_e              state_q,      state_d;
    logic                aer_req_n_q,  aer_req_n_d;
    logic [AER_BITS-1:0] aer_data_q,   aer_data_d;
    logic [TMR_W-1:0]    timer_q,      timer_d;
    logic                opkt_rdy_q,   opkt_rdy_d;
    logic                dump_mode_q,  dump_mode_d;
    logic                drop_pulse_q, drop_pulse_d;

    logic ack_s;
    key_t key_s;
    logic fwd_ok_s;
    logic xfer_s;
    logic unused_s;

    aer_sync2 #(
        .RST_VAL(1'b1)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst),
        .d    (aer_ack_n),
        .q    (ack_s)
    );

    assign key_s    = opkt_data[KEY_LSB +: KEY_BITS];
    assign fwd_ok_s = is_multicast(opkt_data[HDR_TYPE_MSB:HDR_TYPE_LSB])
                      && ((key_s & KEY_MASK) == KEY_MATCH);
    assign xfer_s   = opkt_vld && opkt_rdy_q;

    // Payload and the non-type header bits never influence forwarding
    assign unused_s = ^{opkt_data[PKT_BITS-1:KEY_LSB+KEY_BITS],
                        opkt_data[HDR_TYPE_LSB-1:0]};

    // Handshake sequencing, filtering and per-phase ack timeout
    always_comb begin
        state_d      = state_q;
        aer_req_n_d  = aer_req_n_q;
        aer_data_d   = aer_data_q;
        timer_d      = timer_q;
        drop_pulse_d = 1'b0;

        case (state_q)
            IDLE_ST: begin
                if (xfer_s) begin
                    if (go && fwd_ok_s) begin
                        aer_data_d = opkt_data[KEY_LSB +: AER_BITS];
                        state_d    = SETUP_ST;
                    end else begin
                        drop_pulse_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE_ST;
                end
            end
            // Data has been stable for a full cycle before req is asserted
            SETUP_ST: begin
                aer_req_n_d = 1'b0;
                timer_d     = TMR_INIT;
                state_d     = REQ_ST;
            end
            REQ_ST: begin
                if (!ack_s) begin
                    aer_req_n_d = 1'b1;
                    timer_d     = TMR_INIT;
                    state_d     = REL_ST;
                end else if (timer_q == TMR_ZERO) begin
                    aer_req_n_d = 1'b1;
                    state_d     = DUMP_ST;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            REL_ST: begin
                if (ack_s) begin
                    state_d = IDLE_ST;
                end else if (timer_q == TMR_ZERO) begin
                    state_d = DUMP_ST;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            DUMP_ST: begin
                aer_req_n_d  = 1'b1;
                drop_pulse_d = xfer_s;
                if (ack_s) begin
                    state_d = IDLE_ST;
                end else begin
                    state_d = DUMP_ST;
                end
            end
            default: begin
                aer_req_n_d = 1'b1;
                state_d     = IDLE_ST;
            end
        endcase

        // Ready and dump flags track the state being entered so they stay registered
        opkt_rdy_d  = (state_d == IDLE_ST) || (state_d == DUMP_ST);
        dump_mode_d = (state_d == DUMP_ST);
    end

    // State and registered outputs; reset returns the AER bus to idle at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE_ST;
            aer_req_n_q  <= 1'b1;
            aer_data_q   <= {AER_BITS{1'b0}};
            timer_q      <= TMR_INIT;
            opkt_rdy_q   <= 1'b0;
            dump_mode_q  <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            aer_req_n_q  <= aer_req_n_d;
            aer_data_q   <= aer_data_d;
            timer_q      <= timer_d;
            opkt_rdy_q   <= opkt_rdy_d;
            dump_mode_q  <= dump_mode_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    assign aer_req_n  = aer_req_n_q;
    assign aer_data   = aer_data_q;
    assign opkt_rdy   = opkt_rdy_q;
    assign dump_mode  = dump_mode_q;
    assign drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_spinn_aer_out_if.sv
// Self-checking bench for spinn_aer_out_if: vector table plus handshake,
// timeout, stuck-ack, go-gating and asynchronous-reset sequences.
module tb_spinn_aer_out_if;

    localparam int RX_AUTO  = 0;
    localparam int RX_NEVER = 1;
    localparam int RX_STUCK = 2;

    logic        clk;
    logic        rst;
    logic        go;
    logic        dump_mode;
    logic        drop_pulse;
    logic [71:0] opkt_data;
    logic        opkt_vld;
    logic        opkt_rdy;
    logic [15:0] aer_data;
    logic        aer_req_n;
    logic        aer_ack_n;

    typedef struct {
        logic [31:0] pay;
        logic [31:0] key;
        logic [7:0]  hdr;
        logic        go;
        logic        fwd;
        logic [15:0] addr;
    } vec_t;

    vec_t        vecs[13];
    logic [15:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rx_mode = RX_AUTO;
    int rx_cnt = 0;
    int ack_dly = 3;
    int rel_dly = 3;
    int ack_chg_cyc = 0;
    int drop_seen = 0;
    int exp_drops = 0;
    int dump_seen = 0;
    logic        prev_req_n = 1'b1;
    logic [15:0] prev_data = 16'h0000;

    spinn_aer_out_if dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .dump_mode (dump_mode),
        .drop_pulse(drop_pulse),
        .opkt_data (opkt_data),
        .opkt_vld  (opkt_vld),
        .opkt_rdy  (opkt_rdy),
        .aer_data  (aer_data),
        .aer_req_n (aer_req_n),
        .aer_ack_n (aer_ack_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input longint act, input longint lo, input longint hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One clock: receiver reacts after the edge, monitor samples at the falling edge
    task automatic step();
        logic [15:0] e;
        logic        old_ack;
        @(posedge clk);
        cyc++;
        #1;
        old_ack = aer_ack_n;
        case (rx_mode)
            RX_STUCK: aer_ack_n = 1'b0;
            RX_NEVER: aer_ack_n = 1'b1;
            default: begin
                if (!aer_req_n && aer_ack_n) begin
                    if (rx_cnt >= ack_dly) begin aer_ack_n = 1'b0; rx_cnt = 0; end
                    else rx_cnt++;
                end else if (aer_req_n && !aer_ack_n) begin
                    if (rx_cnt >= rel_dly) begin aer_ack_n = 1'b1; rx_cnt = 0; end
                    else rx_cnt++;
                end else begin
                    rx_cnt = 0;
                end
            end
        endcase
        if (aer_ack_n != old_ack) ack_chg_cyc = cyc;
        @(negedge clk);
        if (prev_req_n && !aer_req_n) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_req: got request with addr %0h, expected none", aer_data);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", aer_data, e);
                check("setup_addr", prev_data, e);
            end
        end
        if (drop_pulse) drop_seen++;
        if (dump_mode) begin
            dump_seen++;
            check("dump_req_n", aer_req_n, 1);
        end
        prev_req_n = aer_req_n;
        prev_data  = aer_data;
    endtask

    task automatic send_pkt(input logic [71:0] pkt, input logic fwd, input logic [15:0] addr,
                            output int waited);
        opkt_data = pkt;
        opkt_vld  = 1'b1;
        waited    = 0;
        while (!opkt_rdy && waited < 200) begin
            step();
            waited++;
        end
        if (!opkt_rdy) begin
            check("accept_timeout", 0, 1);
        end else begin
            if (fwd) exp_q.push_back(addr);
            else exp_drops++;
            step();
            waited++;
            check("drop_pulse", drop_pulse, !fwd);
        end
        opkt_vld = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(opkt_rdy && !dump_mode && aer_req_n && aer_ack_n) && n < 300) begin
            step();
            n++;
        end
        check({nm, "_idle_reached"}, (n < 300), 1);
        check({nm, "_events_left"}, exp_q.size(), 0);
        check({nm, "_drops"}, drop_seen, exp_drops);
        exp_q.delete();
        drop_seen = 0;
        exp_drops = 0;
    endtask

    initial begin
        int          w;
        int          n;
        int          t0;
        int          dump0;
        logic [15:0] a;

        vecs[0]  = '{32'h0000_0000, 32'h0000_1234, 8'h00, 1'b1, 1'b1, 16'h1234};
        vecs[1]  = '{32'h0000_0000, 32'h0001_0055, 8'h00, 1'b1, 1'b0, 16'h0000};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0077, 8'h40, 1'b1, 1'b0, 16'h0000};
        vecs[3]  = '{32'h0000_0000, 32'h0000_FFFF, 8'h00, 1'b1, 1'b1, 16'hFFFF};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0001, 8'h80, 1'b1, 1'b0, 16'h0000};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0002, 8'hC0, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{32'h0000_0000, 32'h0000_A5A5, 8'h3F, 1'b1, 1'b1, 16'hA5A5};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 8'h00, 1'b1, 1'b1, 16'h0000};
        vecs[8]  = '{32'h0000_0000, 32'hFFFF_0000, 8'h00, 1'b1, 1'b0, 16'h0000};
        vecs[9]  = '{32'h0000_0000, 32'h8000_1234, 8'h00, 1'b1, 1'b0, 16'h0000};
        vecs[10] = '{32'h0000_0000, 32'h0000_1234, 8'h00, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{32'hDEAD_BEEF, 32'h0000_5A5A, 8'h01, 1'b1, 1'b1, 16'h5A5A};
        vecs[12] = '{32'hFFFF_FFFF, 32'h0000_8001, 8'h00, 1'b1, 1'b1, 16'h8001};

        rst       = 1'b1;
        go        = 1'b1;
        opkt_vld  = 1'b0;
        opkt_data = 72'h0;
        aer_ack_n = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_req_n", aer_req_n, 1);
        check("rst_data", aer_data, 16'h0000);
        check("rst_rdy", opkt_rdy, 0);
        check("rst_dump", dump_mode, 0);
        check("rst_drop", drop_pulse, 0);
        step();
        step();
        check("rst_hold_req_n", aer_req_n, 1);
        rst = 1'b1;
        #1;
        check("rdy_first_cycle", opkt_rdy, 0);
        step();
        check("rdy_after_rst", opkt_rdy, 1);
        check("dump_after_rst", dump_mode, 0);

        // Forwarded event with a receiver acking after 3 cycles and releasing 3 later
        send_pkt({32'h0, 32'h0000_1234, 8'h00}, 1'b1, 16'h1234, w);
        check("fwd_setup_req_n", aer_req_n, 1);
        check("fwd_setup_data", aer_data, 16'h1234);
        check("fwd_setup_rdy", opkt_rdy, 0);
        step();
        check("fwd_req_fall", aer_req_n, 0);
        n = 0; while (aer_ack_n && n < 20) begin step(); n++; end
        t0 = ack_chg_cyc;
        n = 0; while (!aer_req_n && n < 20) begin step(); n++; end
        check_range("fwd_req_rise_lat", cyc - t0, 2, 3);
        n = 0; while (!aer_ack_n && n < 20) begin step(); n++; end
        t0 = ack_chg_cyc;
        n = 0; while (!opkt_rdy && n < 20) begin step(); n++; end
        check_range("fwd_rdy_lat", cyc - t0, 2, 3);
        wait_idle("fwd");

        foreach (vecs[i]) begin
            go = vecs[i].go;
            send_pkt({vecs[i].pay, vecs[i].key, vecs[i].hdr}, vecs[i].fwd, vecs[i].addr, w);
            check($sformatf("vec%0d_accept", i), w, 1);
            wait_idle($sformatf("vec%0d", i));
        end
        go = 1'b1;

        // Filtered packets back to back: one cycle each, no request
        send_pkt({32'h0, 32'h0001_0055, 8'h00}, 1'b0, 16'h0000, w);
        check("filt1_accept", w, 1);
        send_pkt({32'h0, 32'h0000_0042, 8'h40}, 1'b0, 16'h0000, w);
        check("filt2_accept", w, 1);
        check("filt_req_n", aer_req_n, 1);
        wait_idle("filter");

        // Receiver never acks: timeout in REQ, one dump cycle, repeated
        rx_mode = RX_NEVER;
        for (int k = 0; k < 2; k++) begin
            a = 16'h0100 + 16'(k);
            send_pkt({32'h0, 16'h0000, a, 8'h00}, 1'b1, a, w);
            n = 0; while (aer_req_n && n < 5) begin step(); n++; end
            n = 0; while (!aer_req_n && n < 100) begin step(); n++; end
            check($sformatf("to%0d_req_low", k), n, 32);
            n = 0; while (dump_mode && n < 10) begin step(); n++; end
            check($sformatf("to%0d_dump_cycles", k), n, 1);
            wait_idle("timeout");
        end

        // Ack stuck low: first event times out in release, then dump drops
        rx_mode = RX_STUCK;
        step(); step(); step();
        send_pkt({32'h0, 32'h0000_0ABC, 8'h00}, 1'b1, 16'h0ABC, w);
        send_pkt({32'h0, 32'h0000_0011, 8'h00}, 1'b0, 16'h0000, w);
        check_range("stuck_p2_wait", w, 30, 40);
        send_pkt({32'h0, 32'h0000_0012, 8'h00}, 1'b0, 16'h0000, w);
        check("stuck_p3_accept", w, 1);
        send_pkt({32'h0, 32'h0000_0013, 8'h00}, 1'b0, 16'h0000, w);
        check("stuck_p4_accept", w, 1);
        check("stuck_dump", dump_mode, 1);
        rx_mode = RX_NEVER;
        n = 0; while (dump_mode && n < 10) begin step(); n++; end
        check_range("stuck_clear_lat", cyc - ack_chg_cyc, 2, 3);
        wait_idle("stuck");

        // go low drops everything; go falling mid-handshake lets it finish
        rx_mode = RX_AUTO;
        ack_dly = 6;
        go      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a = 16'h0200 + 16'(k);
            send_pkt({32'h0, 16'h0000, a, 8'h00}, 1'b0, 16'h0000, w);
            check($sformatf("go0_p%0d_accept", k), w, 1);
        end
        check("go0_req_n", aer_req_n, 1);
        wait_idle("go0");
        go = 1'b1;
        dump0 = dump_seen;
        send_pkt({32'h0, 32'h0000_0300, 8'h00}, 1'b1, 16'h0300, w);
        n = 0; while (aer_req_n && n < 10) begin step(); n++; end
        go = 1'b0;
        wait_idle("go_fall");
        check("go_fall_no_dump", dump_seen - dump0, 0);
        go      = 1'b1;
        ack_dly = 3;

        // Asynchronous reset while waiting for ack
        rx_mode = RX_NEVER;
        send_pkt({32'h0, 32'h0000_0BAD, 8'h00}, 1'b1, 16'h0BAD, w);
        n = 0; while (aer_req_n && n < 10) begin step(); n++; end
        step(); step(); step();
        check("pre_arst_req_n", aer_req_n, 0);
        #2 rst = 1'b0;
        #1;
        check("arst_req_n", aer_req_n, 1);
        check("arst_rdy", opkt_rdy, 0);
        check("arst_dump", dump_mode, 0);
        step();
        step();
        rst     = 1'b1;
        rx_mode = RX_AUTO;
        send_pkt({32'h0, 32'h0000_0C0D, 8'h00}, 1'b1, 16'h0C0D, w);
        wait_idle("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spinn_aer_out_if.md
Name: spinn_aer_out_if

Overview:
- Outbound bridge from SpiNNaker to AER. It accepts multicast packets from the SpiNNaker packet interface, extracts an event address from the routing key, and drives it onto an asynchronous 4-phase AER bus (active-low req/ack).
- It guards against a stalled AER receiver with an ack timeout and a dump mode, so SpiNNaker is never back-pressured indefinitely.
- Sits beside the inbound AER->SpiNNaker dump interface in the SpiNNaker-link top level.

Parameters:
- PKT_BITS, 72: SpiNNaker packet width (`PKT_BITS); bits [7:0] header, [39:8] key.
- AER_BITS, 16: AER address width; the address is key[AER_BITS-1:0], i.e. pkt[AER_BITS+7:8].
- KEY_MASK, 32'hFFFF0000: key bits compared against KEY_MATCH.
- KEY_MATCH, 32'h00000000: required value of (key & KEY_MASK) for forwarding.
- ACK_TIMEOUT, 31: cycles allowed per handshake phase before dump.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- go  in  1  1 = forward events; 0 = consume and drop all packets
- dump_mode  out  1  high while in DUMP_ST
- drop_pulse  out  1  one-cycle pulse per packet accepted but not forwarded
- opkt_data  in  PKT_BITS  SpiNNaker packet
- opkt_vld  in  1  packet valid
- opkt_rdy  out  1  packet accepted when vld&rdy
- aer_data  out  AER_BITS  AER address
- aer_req_n  out  1  AER request, active-low
- aer_ack_n  in  1  AER acknowledge, active-low, asynchronous

Behaviour:
- Reset (rst=0): state=IDLE_ST, aer_req_n=1, aer_data=0, opkt_rdy=0, dump_mode=0, drop_pulse=0, timer=ACK_TIMEOUT. The ack synchroniser is preset to 1.
- aer_ack_n passes through a 2-flop synchroniser; ack_s is the synchronised value (2-cycle latency).
- Forwardable packet: header[7:6]==2'b00 (multicast) and (key & KEY_MASK)==KEY_MATCH.
- opkt_rdy = 1 only in IDLE_ST and DUMP_ST. It is registered, so it is 0 in the first cycle after reset release.
- Transfer occurs when opkt_vld && opkt_rdy. Data must stay stable while vld is high and rdy is low.
- States:
  - IDLE_ST:
    - Transfer of a forwardable packet with go=1: latch aer_data=pkt[AER_BITS+7:8], go to SETUP_ST.
    - Any other transfer: drop_pulse=1, stay in IDLE_ST.
  - SETUP_ST: one cycle with aer_data stable and req_n still 1 (data-before-req setup); then aer_req_n<=0, timer<=ACK_TIMEOUT, go to REQ_ST.
  - REQ_ST:
    - ack_s==0: aer_req_n<=1, timer<=ACK_TIMEOUT, go to REL_ST.
    - Else if timer==0: aer_req_n<=1, go to DUMP_ST.
    - Else: timer decrements.
  - REL_ST:
    - ack_s==1: go to IDLE_ST.
    - Else if timer==0: go to DUMP_ST.
    - Else: timer decrements.
  - DUMP_ST:
    - dump_mode=1, opkt_rdy=1.
    - Every accepted packet is dropped (drop_pulse=1), forwardable or not; aer_req_n is held 1.
    - ack_s==1 at a clock edge: go to IDLE_ST.
- The abandoned event is not counted in drop_pulse.
- Ack-edge/timeout coincidence: if ack_s changes in the same cycle timer==0, the ack wins.
- go falling mid-handshake (SETUP/REQ/REL): the current handshake completes normally; go is sampled only in IDLE_ST.
- Minimum forwarded-event period with an instant receiver is about 7 cycles (1 setup, 2 sync, 2 sync, transitions). Throughput is not a requirement beyond that bound.
- aer_data holds its value after an event until the next latch.
- Reset asserted mid-handshake: req_n returns to 1 asynchronously and the event is lost.

Decomposition:
- Shared package/header (spio_spinnaker_link.h):
  - `PKT_BITS
  - header field positions: type [7:6], key [39:8]
  - MC type code 2'b00
- State encoding localparams stay local to the block.
- Natural sub-module: aer_sync2 (2-flop synchroniser with async active-low reset and preset value parameter). It is reusable by the inbound interface.

Test Plan:
- Forward: go=1, MC packet with key 32'h0000_1234, receiver acks after 3 cycles and releases after 3 more. Expect:
  - aer_data=16'h1234 one cycle before aer_req_n falls;
  - req_n rises 2 cycles after ack_n falls;
  - opkt_rdy returns 2 cycles after ack_n rises;
  - no drop_pulse.
- Filter: key 32'h0001_0055 (mask mismatch), then an NN packet (header[7:6]=2'b01). Expect:
  - both consumed in 1 cycle each;
  - two drop_pulses;
  - aer_req_n stays 1.
- Timeout: receiver never acks (ack_n=1), ACK_TIMEOUT=31. Expect:
  - req_n low for 32 cycles, then high;
  - dump_mode=1 for 1 cycle, then IDLE;
  - the next packet repeats the same pattern.
- Stuck ack: ack_n held 0 throughout; send 4 packets back-to-back. Expect:
  - first event times out in REL_ST, giving dump_mode=1;
  - following 3 packets consumed one per cycle with 3 drop_pulses;
  - on ack_n=1, dump_mode clears 2-3 cycles later.
- go gating: go=0 with 5 valid packets. Expect 5 drop_pulses and no req. Drop go to 0 while in REQ_ST: the handshake still completes.
- Reset mid-REQ_ST: assert rst=0. Expect aer_req_n=1, opkt_rdy=0 and dump_mode=0 immediately (asynchronously); after release, the next packet is forwarded normally.
